reg_file: RTL and testbench

//  Architectural register file plus register-status (rename) table for the Tomasulo core.

---
 rtl/reg_file_pkg.sv | 16 +
 rtl/reg_file_read_port.sv | 39 +++
 rtl/reg_file.sv | 109 ++++++++++
 tb/tb_reg_file.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/reg_file_pkg.sv
// Shared widths and types for the register file / rename table slice.
package reg_file_pkg;

    localparam int unsigned REG_NUM       = 32;
    localparam int unsigned REG_POS_WIDTH = 5;
    localparam int unsigned ROB_POS_WIDTH = 4;
    localparam int unsigned DATA_WIDTH    = 32;

    typedef logic [REG_POS_WIDTH-1:0] reg_pos_t;
    typedef logic [ROB_POS_WIDTH-1:0] rob_pos_t;
    typedef logic [DATA_WIDTH-1:0]    data_t;

    localparam logic TRUE  = 1'b1;
    localparam logic FALSE = 1'b0;

endpackage

// File: rtl/reg_file_read_port.sv
// One source-operand read port: selects stored state and applies the
// same-cycle commit bypass so a consumer never waits on an already
// retiring producer.
module reg_file_read_port
    import reg_file_pkg::*;
(
    input  reg_pos_t             rs_pos,
    input  data_t                val_q [REG_NUM],
    input  logic [REG_NUM-1:0]   busy_q,
    input  rob_pos_t             tag_q [REG_NUM],
    input  logic                 commit_valid,
    input  reg_pos_t             commit_rd,
    input  data_t                commit_val,
    input  rob_pos_t             commit_rob_pos,
    output logic                 rs_busy,
    output data_t                rs_val,
    output rob_pos_t             rs_rob_pos
);

    logic hit;

    // Stored state by default; the committing producer's value overrides a pending entry.
    always_comb begin
        rs_busy    = busy_q[rs_pos];
        rs_val     = val_q[rs_pos];
        rs_rob_pos = tag_q[rs_pos];
        hit        = commit_valid && (commit_rd == rs_pos) && (rs_pos != '0)
                     && busy_q[rs_pos] && (tag_q[rs_pos] == commit_rob_pos);
        if (hit) begin
            rs_busy = FALSE;
            rs_val  = commit_val;
        end
        if (rs_pos == '0) begin
            rs_busy = FALSE;
            rs_val  = '0;
        end
    end

endmodule

// File: rtl/reg_file.sv
// Architectural register file plus rd->ROB-tag rename table. Owns all
// storage; two read ports answer decoder operand queries.
module reg_file
    import reg_file_pkg::*;
(
    input  logic     clk,
    input  logic     rst,
    input  logic     rdy,
    input  logic     rollback,
    input  logic     issue_enable,
    input  reg_pos_t issue_rd,
    input  rob_pos_t issue_rob_pos,
    input  logic     commit_enable,
    input  reg_pos_t commit_rd,
    input  data_t    commit_val,
    input  rob_pos_t commit_rob_pos,
    input  reg_pos_t rs1_pos,
    input  reg_pos_t rs2_pos,
    output logic     rs1_busy,
    output data_t    rs1_val,
    output rob_pos_t rs1_rob_pos,
    output logic     rs2_busy,
    output data_t    rs2_val,
    output rob_pos_t rs2_rob_pos
);

    data_t              val_q [REG_NUM];
    data_t              val_d [REG_NUM];
    rob_pos_t           tag_q [REG_NUM];
    rob_pos_t           tag_d [REG_NUM];
    logic [REG_NUM-1:0] busy_q;
    logic [REG_NUM-1:0] busy_d;

    logic commit_wr;
    logic issue_wr;
    logic commit_valid;

    assign commit_wr    = commit_enable && (commit_rd != '0);
    assign issue_wr     = issue_enable && (issue_rd != '0);
    assign commit_valid = commit_enable && rdy;

    // Next-state: rollback wipes the rename table but committed values still land;
    // issue is applied after commit so a same-cycle re-issue keeps the entry busy.
    always_comb begin
        val_d  = val_q;
        tag_d  = tag_q;
        busy_d = busy_q;
        if (rdy) begin
            if (commit_wr) begin
                val_d[commit_rd] = commit_val;
            end
            if (rollback) begin
                busy_d = '0;
                tag_d  = '{default: '0};
            end else begin
                if (commit_wr && (tag_q[commit_rd] == commit_rob_pos)
                    && !(issue_wr && (issue_rd == commit_rd))) begin
                    busy_d[commit_rd] = FALSE;
                end
                if (issue_wr) begin
                    busy_d[issue_rd] = TRUE;
                    tag_d[issue_rd]  = issue_rob_pos;
                end
            end
        end
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            val_q  <= '{default: '0};
            tag_q  <= '{default: '0};
            busy_q <= '0;
        end else begin
            val_q  <= val_d;
            tag_q  <= tag_d;
            busy_q <= busy_d;
        end
    end

    reg_file_read_port u_rs1 (
        .rs_pos         (rs1_pos),
        .val_q          (val_q),
        .busy_q         (busy_q),
        .tag_q          (tag_q),
        .commit_valid   (commit_valid),
        .commit_rd      (commit_rd),
        .commit_val     (commit_val),
        .commit_rob_pos (commit_rob_pos),
        .rs_busy        (rs1_busy),
        .rs_val         (rs1_val),
        .rs_rob_pos     (rs1_rob_pos)
    );

    reg_file_read_port u_rs2 (
        .rs_pos         (rs2_pos),
        .val_q          (val_q),
        .busy_q         (busy_q),
        .tag_q          (tag_q),
        .commit_valid   (commit_valid),
        .commit_rd      (commit_rd),
        .commit_val     (commit_val),
        .commit_rob_pos (commit_rob_pos),
        .rs_busy        (rs2_busy),
        .rs_val         (rs2_val),
        .rs_rob_pos     (rs2_rob_pos)
    );

endmodule

// File: tb/tb_reg_file.sv
// Scoreboard bench for reg_file: stimulus queues expected query results,
// a negedge monitor pops and compares them against the read ports.
module tb_reg_file;

    logic        clk = 1'b0;
    logic        rst;
    logic        rdy;
    logic        rollback;
    logic        issue_enable;
    logic [4:0]  issue_rd;
    logic [3:0]  issue_rob_pos;
    logic        commit_enable;
    logic [4:0]  commit_rd;
    logic [31:0] commit_val;
    logic [3:0]  commit_rob_pos;
    logic [4:0]  rs1_pos;
    logic [4:0]  rs2_pos;
    logic        rs1_busy;
    logic [31:0] rs1_val;
    logic [3:0]  rs1_rob_pos;
    logic        rs2_busy;
    logic [31:0] rs2_val;
    logic [3:0]  rs2_rob_pos;

    always #5 clk = ~clk;

    reg_file dut (
        .clk            (clk),
        .rst            (rst),
        .rdy            (rdy),
        .rollback       (rollback),
        .issue_enable   (issue_enable),
        .issue_rd       (issue_rd),
        .issue_rob_pos  (issue_rob_pos),
        .commit_enable  (commit_enable),
        .commit_rd      (commit_rd),
        .commit_val     (commit_val),
        .commit_rob_pos (commit_rob_pos),
        .rs1_pos        (rs1_pos),
        .rs2_pos        (rs2_pos),
        .rs1_busy       (rs1_busy),
        .rs1_val        (rs1_val),
        .rs1_rob_pos    (rs1_rob_pos),
        .rs2_busy       (rs2_busy),
        .rs2_val        (rs2_val),
        .rs2_rob_pos    (rs2_rob_pos)
    );

    typedef struct {
        string       name;
        bit          port;   // 0 = rs1, 1 = rs2
        logic        busy;
        logic [31:0] val;
        logic [3:0]  rob;
        bit          all;    // compare val and rob regardless of busy
    } exp_t;

    exp_t sb[$];
    int   n_vec = 0;
    int   n_bad = 0;

    task automatic expect_q(input string name, input bit port, input logic busy,
                            input logic [31:0] val, input logic [3:0] rob, input bit all);
        exp_t e;
        e.name = name; e.port = port; e.busy = busy; e.val = val; e.rob = rob; e.all = all;
        sb.push_back(e);
    endtask

    // Monitor: outputs are combinational, so every queued expectation is checked mid-cycle.
    exp_t        m;
    logic        a_busy;
    logic [31:0] a_val;
    logic [3:0]  a_rob;
    bit          bad;
    always @(negedge clk) begin
        while (sb.size() > 0) begin
            m      = sb.pop_front();
            a_busy = m.port ? rs2_busy    : rs1_busy;
            a_val  = m.port ? rs2_val     : rs1_val;
            a_rob  = m.port ? rs2_rob_pos : rs1_rob_pos;
            bad    = (a_busy !== m.busy)
                     || ((m.busy || m.all) && (a_rob !== m.rob))
                     || ((!m.busy || m.all) && (a_val !== m.val));
            n_vec++;
            if (bad) begin
                n_bad++;
                $display("FAIL %s: got busy=%0b val=%h rob=%0d, want busy=%0b val=%h rob=%0d",
                         m.name, a_busy, a_val, a_rob, m.busy, m.val, m.rob);
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
        issue_enable  = 1'b0;
        commit_enable = 1'b0;
        rollback      = 1'b0;
    endtask

    logic [31:0] exp_val [32];

    initial begin
        rst = 1'b1; rdy = 1'b1; rollback = 1'b0;
        issue_enable = 1'b0; issue_rd = '0; issue_rob_pos = '0;
        commit_enable = 1'b0; commit_rd = '0; commit_val = '0; commit_rob_pos = '0;
        rs1_pos = '0; rs2_pos = '0;
        step(); step();
        rst = 1'b0;

        // Reset state
        rs1_pos = 5; rs2_pos = 31;
        expect_q("reset_x5", 0, 0, 32'h0, 4'd0, 1);
        expect_q("reset_x31", 1, 0, 32'h0, 4'd0, 1);
        step();

        // 1: issue / query / bypass commit
        issue_enable = 1; issue_rd = 5; issue_rob_pos = 3;
        rs1_pos = 5;
        expect_q("t1_pre_issue", 0, 0, 32'h0, 4'd0, 0);
        step();
        expect_q("t1_busy", 0, 1, 32'h0, 4'd3, 0);
        step();
        commit_enable = 1; commit_rd = 5; commit_rob_pos = 3; commit_val = 32'hDEADBEEF;
        rs1_pos = 5; rs2_pos = 5;
        expect_q("t1_bypass_rs1", 0, 0, 32'hDEADBEEF, 4'd0, 0);
        expect_q("t1_bypass_rs2", 1, 0, 32'hDEADBEEF, 4'd0, 0);
        step();
        expect_q("t1_stored", 0, 0, 32'hDEADBEEF, 4'd0, 0);
        step();

        // 2: stale-tag commit leaves newer mapping busy
        issue_enable = 1; issue_rd = 7; issue_rob_pos = 2;
        step();
        issue_enable = 1; issue_rd = 7; issue_rob_pos = 6;
        rs2_pos = 7;
        expect_q("t2_old_tag", 1, 1, 32'h0, 4'd2, 0);
        step();
        commit_enable = 1; commit_rd = 7; commit_rob_pos = 2; commit_val = 32'h11;
        rs1_pos = 7;
        expect_q("t2_no_bypass", 0, 1, 32'h0, 4'd6, 0);
        step();
        expect_q("t2_still_busy", 0, 1, 32'h0, 4'd6, 0);
        step();

        // 3: same-cycle issue and commit on x9
        issue_enable = 1; issue_rd = 9; issue_rob_pos = 1;
        step();
        issue_enable = 1; issue_rd = 9; issue_rob_pos = 4;
        commit_enable = 1; commit_rd = 9; commit_rob_pos = 1; commit_val = 32'h22;
        rs1_pos = 9;
        expect_q("t3_bypass", 0, 0, 32'h22, 4'd0, 0);
        step();
        expect_q("t3_reissued", 0, 1, 32'h0, 4'd4, 0);
        step();

        // 4: x0 is hardwired
        issue_enable = 1; issue_rd = 0; issue_rob_pos = 5;
        commit_enable = 1; commit_rd = 0; commit_rob_pos = 0; commit_val = 32'h99;
        rs1_pos = 0; rs2_pos = 0;
        expect_q("t4_x0_rs1", 0, 0, 32'h0, 4'd0, 0);
        expect_q("t4_x0_rs2", 1, 0, 32'h0, 4'd0, 0);
        step();
        expect_q("t4_x0_after", 0, 0, 32'h0, 4'd0, 0);
        step();

        // 5: busy x1..x31 then rollback with a commit to x3
        for (int i = 1; i < 32; i++) begin
            issue_enable = 1; issue_rd = 5'(i); issue_rob_pos = 4'(i % 16);
            step();
        end
        rs1_pos = 20;
        expect_q("t5_x20_busy", 0, 1, 32'h0, 4'd4, 0);
        rollback = 1;
        commit_enable = 1; commit_rd = 3; commit_rob_pos = 3; commit_val = 32'h33;
        issue_enable = 1; issue_rd = 12; issue_rob_pos = 9;
        rs2_pos = 3;
        expect_q("t5_rb_bypass", 1, 0, 32'h33, 4'd0, 0);
        step();
        for (int i = 0; i < 32; i++) exp_val[i] = 32'h0;
        exp_val[3] = 32'h33; exp_val[5] = 32'hDEADBEEF; exp_val[7] = 32'h11; exp_val[9] = 32'h22;
        for (int i = 1; i < 32; i++) begin
            rs1_pos = 5'(i);
            expect_q($sformatf("t5_after_rb_x%0d", i), 0, 0, exp_val[i], 4'd0, 1);
            step();
        end

        // 6: rdy low freezes state
        rdy = 0;
        issue_enable = 1; issue_rd = 10; issue_rob_pos = 7;
        commit_enable = 1; commit_rd = 5; commit_rob_pos = 0; commit_val = 32'h55;
        rs1_pos = 10; rs2_pos = 5;
        expect_q("t6_frz_x10", 0, 0, 32'h0, 4'd0, 1);
        expect_q("t6_frz_x5", 1, 0, 32'hDEADBEEF, 4'd0, 1);
        step();
        rdy = 1;
        expect_q("t6_held_x10", 0, 0, 32'h0, 4'd0, 1);
        expect_q("t6_held_x5", 1, 0, 32'hDEADBEEF, 4'd0, 1);
        step();
        issue_enable = 1; issue_rd = 20; issue_rob_pos = 11;
        step();
        rst = 1;
        rs1_pos = 20;
        expect_q("t6_pre_rst_x20", 0, 1, 32'h0, 4'd11, 0);
        step();
        rst = 0;
        rs1_pos = 20; rs2_pos = 5;
        expect_q("t6_rst_x20", 0, 0, 32'h0, 4'd0, 1);
        expect_q("t6_rst_x5", 1, 0, 32'h0, 4'd0, 1);
        step();
        step();

        if (sb.size() != 0) begin
            $display("FAIL scoreboard_drain: got %0d pending, want 0", sb.size());
            n_bad += sb.size();
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
